sram_like_responder: RTL and testbench

- Slave (responder) end of the SRAM-like request/response interface used by the pipeline's fetch and memory stages.
- Accepts requests with an addr_ok handshake and issues them to a word-wide synchronous single-port RAM with 1-cycle read latency.
- Returns strictly in-order data_ok/rdata after a configurable extra delay, with bounded outstanding requests.
- Serves as the inst/data SRAM model behind the CPU in simulation and as the template for the later AXI bridge.

---
 rtl/sram_like_responder_pkg.sv | 28 ++
 rtl/sram_like_responder_resp_fifo.sv | 77 +++++++
 rtl/sram_like_responder.sv | 145 ++++++++++++++
 tb/tb_sram_like_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the SRAM-like responder: transfer size encodings,
// response FIFO geometry and the outstanding-counter width.
package sram_like_responder_pkg;

  // Transfer size encodings carried on sram_size (informational only here).
  localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } sram_size_e;

  // Response FIFO payload width (one RAM word).
  localparam int RESP_FIFO_WIDTH = 32;

  // Outstanding counter width; MAX_OUT is at most 4, so 3 bits never saturate.
  localparam int CNT_W = 3;

  // Drop the byte offset: the RAM is word-addressed on a byte address bus.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// Small synchronous show-ahead FIFO holding read data between the RAM
// read cycle and the delayed data_ok cycle. The head entry is visible
// combinationally because the response cannot wait a cycle for it.
module sram_like_responder_resp_fifo
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = RESP_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(DEPTH);

  logic [WIDTH-1:0]  mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_FW-1:0] count_reg;

  // Circular pointer advance that wraps on non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == DEPTH_C);
  assign pop_data = mem_reg[rd_ptr_reg];

  // Storage array: written on push, no reset needed for payload.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and occupancy; reset discards any buffered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Underflow/overflow would mean the outstanding counter lost track.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop && empty));
      assert (!(push && full && !pop));
    end
  end
`endif

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like request/response interface. Accepts
// requests with addr_ok, issues them straight to a 1-cycle-latency
// synchronous RAM and returns in-order data_ok/rdata DATA_DELAY cycles
// after the RAM read data appears.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int MAX_OUT     = 2,
  parameter int DATA_DELAY  = 0,
  parameter int RESET_DRAIN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_req,
  input  logic        sram_wr,
  input  logic [1:0]  sram_size,
  input  logic [3:0]  sram_wstrb,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic        sram_addr_ok,
  output logic        sram_data_ok,
  output logic [31:0] sram_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int TAG_W = DATA_DELAY + 1;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [TAG_W-1:0] tag_reg;
  logic             wr_t1_reg;
  logic             addr_ok_int;
  logic             accept;
  logic             data_ok_int;
  logic [31:0]      read_word;
  logic             unused_bits;

  // Size and byte offset never change behaviour; alignment faults are
  // raised upstream in the pipeline.
  assign unused_bits = ^{sram_size, sram_addr[1:0]};

  // addr_ok looks only at the registered count, so a response in the
  // same cycle does not reopen the window until the next cycle.
  assign addr_ok_int  = ~reset & (cnt_reg < MAX_OUT_C);
  assign accept       = sram_req & addr_ok_int;
  assign sram_addr_ok = addr_ok_int;

  // RAM issue happens in the acceptance cycle itself.
  assign ram_en    = accept;
  assign ram_wen   = (accept && sram_wr) ? sram_wstrb : 4'h0;
  assign ram_addr  = reset ? 32'h0 : word_align(sram_addr);
  assign ram_wdata = reset ? 32'h0 : sram_wdata;

  // The oldest tag stage marks the response cycle of each request.
  assign data_ok_int  = ~reset & tag_reg[DATA_DELAY];
  assign sram_data_ok = data_ok_int;

  // Word seen on the RAM read port one cycle after acceptance; writes
  // respond with zero.
  assign read_word = wr_t1_reg ? 32'h0 : ram_rdata;

  // Tag pipeline: stage 0 captures acceptance, later stages shift.
  for (genvar gi = 0; gi < TAG_W; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      // Stage 0 is set in the cycle after a request is accepted.
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_reg[gi] <= 1'b0;
        end else begin
          tag_reg[gi] <= accept;
        end
      end
    end else begin : g_body
      // Delay stages advance unconditionally; the master cannot stall.
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_reg[gi] <= 1'b0;
        end else begin
          tag_reg[gi] <= tag_reg[gi-1];
        end
      end
    end
  end

  // Remember whether the request issued last cycle was a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_t1_reg <= 1'b0;
    end else begin
      wr_t1_reg <= accept & sram_wr;
    end
  end

  assign cnt_next = cnt_reg + CNT_W'(accept) - CNT_W'(data_ok_int);

  // Outstanding count: +1 per accept, -1 per response.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  if (DATA_DELAY == 0) begin : g_direct
    // Response coincides with the RAM read cycle: pass the word through.
    assign sram_rdata = data_ok_int ? read_word : 32'h0;
  end else begin : g_fifo
    logic [31:0] fifo_head;
    logic        unused_fifo_empty;
    logic        unused_fifo_full;

    // Every accepted request pushes exactly once (in T+1) and pops on its
    // data_ok, so occupancy is bounded by the outstanding count.
    sram_like_responder_resp_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (RESP_FIFO_WIDTH)
    ) u_resp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tag_reg[0]),
      .push_data (read_word),
      .pop       (data_ok_int),
      .pop_data  (fifo_head),
      .empty     (unused_fifo_empty),
      .full      (unused_fifo_full)
    );

    assign sram_rdata = data_ok_int ? fifo_head : 32'h0;
  end

`ifndef SYNTHESIS
  // Draining in-flight requests across reset is not supported.
  always_ff @(posedge clk) begin
    assert (RESET_DRAIN == 0);
    assert (cnt_reg <= MAX_OUT_C);
  end
`endif

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: four responder instances with different MAX_OUT /
// DATA_DELAY share one stimulus stream; each test checks the instance
// whose configuration it targets. Each instance has its own RAM model.
//   inst 0: MAX_OUT=2 DATA_DELAY=0   inst 1: MAX_OUT=2 DATA_DELAY=1
//   inst 2: MAX_OUT=1 DATA_DELAY=0   inst 3: MAX_OUT=2 DATA_DELAY=2
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_req;
  logic        sram_wr;
  logic [1:0]  sram_size;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;

  logic [3:0]        addr_ok;
  logic [3:0]        data_ok;
  logic [3:0][31:0]  rdata;
  logic [3:0]        ram_en;
  logic [3:0][3:0]   ram_wen;
  logic [3:0][31:0]  ram_addr;
  logic [3:0][31:0]  ram_wdata;

  int total;
  int bad;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    logic [31:0] mem [256];
    logic [31:0] rd_q;
    bit          mem_init = 1'b0;

    sram_like_responder #(
      .MAX_OUT     ((gi == 2) ? 1 : 2),
      .DATA_DELAY  ((gi == 3) ? 2 : ((gi == 1) ? 1 : 0)),
      .RESET_DRAIN (0)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .sram_req     (sram_req),
      .sram_wr      (sram_wr),
      .sram_size    (sram_size),
      .sram_wstrb   (sram_wstrb),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .sram_addr_ok (addr_ok[gi]),
      .sram_data_ok (data_ok[gi]),
      .sram_rdata   (rdata[gi]),
      .ram_en       (ram_en[gi]),
      .ram_wen      (ram_wen[gi]),
      .ram_addr     (ram_addr[gi]),
      .ram_wdata    (ram_wdata[gi]),
      .ram_rdata    (rd_q)
    );

    // Synchronous RAM model, 1-cycle read latency, byte write enables.
    // Word 0 (also 0xbfc00000) and word 0x40 (0x100) hold known values.
    always @(posedge clk) begin
      if (!mem_init) begin
        for (int k = 0; k < 256; k++) begin
          if (k == 0)       mem[k] <= 32'h3c1d0001;
          else if (k == 64) mem[k] <= 32'h11223344;
          else              mem[k] <= {24'ha5a5a5, 8'(k)};
        end
        mem_init <= 1'b1;
      end else if (ram_en[gi]) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_wen[gi][b]) mem[ram_addr[gi][9:2]][8*b +: 8] <= ram_wdata[gi][8*b +: 8];
        end
        rd_q <= mem[ram_addr[gi][9:2]];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic req, input logic wr, input logic [3:0] wstrb,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
    sram_req   = req;
    sram_wr    = wr;
    sram_wstrb = wstrb;
    sram_addr  = addr;
    sram_wdata = wdata;
    sram_size  = size;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, returning at the start of the first post-reset cycle.
  task automatic do_reset();
    tick();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [7:0]  exp_aok2;
  logic [7:0]  exp_dok2;
  logic [31:0] exp_rd2 [8];
  int          n_req;

  initial begin
    total = 0;
    bad   = 0;

    // Reset with garbage on the request bus: nothing may leak through.
    reset = 1'b1;
    drive(1'b1, 1'b1, 4'hf, 32'hffff_ffff, 32'h1234_5678, 2'd2);
    tick();
    @(negedge clk);
    check_val("rst_addr_ok",   32'(addr_ok[0]), 32'h0);
    check_val("rst_data_ok",   32'(data_ok[0]), 32'h0);
    check_val("rst_rdata",     rdata[0],        32'h0);
    check_val("rst_ram_en",    32'(ram_en[0]),  32'h0);
    check_val("rst_ram_wen",   32'(ram_wen[0]), 32'h0);
    check_val("rst_ram_addr",  ram_addr[0],     32'h0);
    check_val("rst_ram_wdata", ram_wdata[0],    32'h0);
    tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    check_val("post_rst_addr_ok", 32'(addr_ok[0]), 32'h1);

    // Single read, DATA_DELAY=0 (inst 0).
    tick();
    drive(1'b1, 1'b0, 4'h0, 32'hbfc00000, 32'h0, 2'd2);
    @(negedge clk);
    check_val("rd1_addr_ok",  32'(addr_ok[0]), 32'h1);
    check_val("rd1_ram_en",   32'(ram_en[0]),  32'h1);
    check_val("rd1_ram_addr", ram_addr[0],     32'hbfc00000);
    check_val("rd1_dok_T",    32'(data_ok[0]), 32'h0);
    tick();
    idle();
    @(negedge clk);
    check_val("rd1_dok_T1",   32'(data_ok[0]), 32'h1);
    check_val("rd1_rdata_T1", rdata[0],        32'h3c1d0001);
    tick();
    @(negedge clk);
    check_val("rd1_dok_T2",   32'(data_ok[0]), 32'h0);
    check_val("rd1_rdata_T2", rdata[0],        32'h0);

    // Back-to-back reads, MAX_OUT=2 DATA_DELAY=1 (inst 1); the master
    // holds each request until it is accepted.
    do_reset();
    exp_aok2 = 8'b1101_1011;  // bit i = cycle T+i
    exp_dok2 = 8'b0110_1100;
    exp_rd2  = '{32'h0, 32'h0, 32'h3c1d0001, 32'ha5a5a501,
                 32'h0, 32'ha5a5a502, 32'ha5a5a503, 32'h0};
    n_req = 0;
    for (int i = 0; i < 8; i++) begin
      if (n_req < 4) drive(1'b1, 1'b0, 4'h0, 32'(n_req * 4), 32'h0, 2'd2);
      else           idle();
      @(negedge clk);
      check_val($sformatf("b2b_aok_%0d", i), 32'(addr_ok[1]), 32'(exp_aok2[i]));
      check_val($sformatf("b2b_dok_%0d", i), 32'(data_ok[1]), 32'(exp_dok2[i]));
      check_val($sformatf("b2b_rd_%0d", i),  rdata[1],        exp_rd2[i]);
      if (sram_req && addr_ok[1]) n_req++;
      tick();
    end

    // Write 0xdeadbeef with strobes 0011 to 0x100, then read it back (inst 0).
    do_reset();
    drive(1'b1, 1'b1, 4'b0011, 32'h100, 32'hdeadbeef, 2'd2);
    @(negedge clk);
    check_val("wr_ram_en",    32'(ram_en[0]),  32'h1);
    check_val("wr_ram_wen",   32'(ram_wen[0]), 32'h3);
    check_val("wr_ram_wdata", ram_wdata[0],    32'hdeadbeef);
    check_val("wr_ram_addr",  ram_addr[0],     32'h100);
    tick();
    drive(1'b1, 1'b0, 4'hf, 32'h100, 32'h0, 2'd2);
    @(negedge clk);
    check_val("rb_addr_ok",  32'(addr_ok[0]), 32'h1);
    check_val("rb_ram_wen",  32'(ram_wen[0]), 32'h0);
    check_val("wr_dok",      32'(data_ok[0]), 32'h1);
    check_val("wr_rdata",    rdata[0],        32'h0);
    tick();
    idle();
    @(negedge clk);
    check_val("rb_dok",   32'(data_ok[0]), 32'h1);
    check_val("rb_rdata", rdata[0],        32'h1122beef);

    // Continuous requests, MAX_OUT=1 DATA_DELAY=0 (inst 2): alternate.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 2'd2);
      @(negedge clk);
      check_val($sformatf("alt_aok_%0d", i), 32'(addr_ok[2]), (i % 2 == 0) ? 32'h1 : 32'h0);
      check_val($sformatf("alt_en_%0d", i),  32'(ram_en[2]),  (i % 2 == 0) ? 32'h1 : 32'h0);
      check_val($sformatf("alt_dok_%0d", i), 32'(data_ok[2]), (i % 2 == 1) ? 32'h1 : 32'h0);
      check_val($sformatf("alt_rd_%0d", i),  rdata[2],        (i % 2 == 1) ? 32'ha5a5a502 : 32'h0);
      tick();
    end
    idle();

    // Reset with two reads in flight, DATA_DELAY=2 (inst 3).
    do_reset();
    drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 2'd2);
    @(negedge clk);
    check_val("mrst_aok_A", 32'(addr_ok[3]), 32'h1);
    tick();
    drive(1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 2'd2);
    @(negedge clk);
    check_val("mrst_aok_B", 32'(addr_ok[3]), 32'h1);
    tick();
    reset = 1'b1;
    idle();
    @(negedge clk);
    check_val("mrst_aok_in_rst", 32'(addr_ok[3]), 32'h0);
    check_val("mrst_dok_in_rst", 32'(data_ok[3]), 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_val("mrst_aok_first", 32'(addr_ok[3]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check_val($sformatf("mrst_dok_%0d", i), 32'(data_ok[3]), 32'h0);
      tick();
    end

    // Misaligned address and byte size are ignored (inst 0).
    do_reset();
    drive(1'b1, 1'b0, 4'h0, 32'h103, 32'h0, 2'd0);
    @(negedge clk);
    check_val("mis_ram_en",   32'(ram_en[0]), 32'h1);
    check_val("mis_ram_addr", ram_addr[0],    32'h100);
    tick();
    idle();
    @(negedge clk);
    check_val("mis_dok",   32'(data_ok[0]), 32'h1);
    check_val("mis_rdata", rdata[0],        32'h1122beef);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
